// File: rtl/wb_epb_master.sv
// Wishbone classic slave to EPB master bridge; each 16-bit Wishbone cycle becomes one EPB transaction.
// Optional `EPB_MASTER_TIMEOUT_EN adds a WAIT-state timeout that answers a stalled target with wb_err_o.
module wb_epb_master #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        epb_cs_n,
  output logic        epb_oe_n,
  output logic        epb_r_w_n,
  output logic [1:0]  epb_be_n,
  output logic [22:0] epb_addr,
  output logic [5:0]  epb_addr_gp,
  output logic [15:0] epb_data_o,
  output logic        epb_data_oe_n,
  input  logic [15:0] epb_data_i,
  input  logic        epb_rdy
);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, HOLD, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        blank_q, blank_d;
  logic        abort_q, abort_d;
  logic        cs_n_q, cs_n_d, oe_n_q, oe_n_d, r_w_n_q, r_w_n_d, doe_n_q, doe_n_d;
  logic [1:0]  be_n_q, be_n_d;
  logic [22:0] addr_q, addr_d;
  logic [5:0]  gp_q, gp_d;
  logic [15:0] dout_q, dout_d, rdat_q, rdat_d;
  logic        ack_q, ack_d;
`ifdef EPB_MASTER_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_st_q, err_st_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    abort_d = abort_q;
    cs_n_d  = cs_n_q;
    oe_n_d  = oe_n_q;
    r_w_n_d = r_w_n_q;
    doe_n_d = doe_n_q;
    be_n_d  = be_n_q;
    addr_d  = addr_q;
    gp_d    = gp_q;
    dout_d  = dout_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
`ifdef EPB_MASTER_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_st_d = err_st_q;
    err_d    = 1'b0;
`endif
    // A request abandoned by the master still finishes on EPB, silently.
    if (state_q != IDLE && !wb_cyc_i) begin
      abort_d = 1'b1;
    end else begin
      abort_d = abort_d;
    end
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d  = wb_adr_i[23:1];
          gp_d    = wb_adr_i[29:24];
          be_n_d  = ~wb_sel_i;
          r_w_n_d = ~wb_we_i;
          dout_d  = wb_dat_i;
          abort_d = 1'b0;
          cnt_d   = 4'd0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
          cs_n_d  = 1'b0;
          oe_n_d  = ~r_w_n_q;
          doe_n_d = r_w_n_q;
          blank_d = 1'b1;
`ifdef EPB_MASTER_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT: begin
        blank_d = 1'b0;
        if (!blank_q && epb_rdy) begin
          if (r_w_n_q) begin
            rdat_d = epb_data_i;
          end else begin
            rdat_d = rdat_q;
          end
`ifdef EPB_MASTER_TIMEOUT_EN
          err_st_d = 1'b0;
`endif
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          doe_n_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = HOLD;
`ifdef EPB_MASTER_TIMEOUT_EN
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          err_st_d = 1'b1;
          cs_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          doe_n_d  = 1'b1;
          cnt_d    = 4'd0;
          state_d  = HOLD;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`else
        end else begin
          state_d = WAIT;
        end
`endif
      end
      HOLD: begin
        if (cnt_q == 4'(HOLD_CYCLES - 1)) begin
`ifdef EPB_MASTER_TIMEOUT_EN
          ack_d = ~abort_d & ~err_st_q;
          err_d = ~abort_d & err_st_q;
`else
          ack_d = ~abort_d;
`endif
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      blank_q <= 1'b0;
      abort_q <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      r_w_n_q <= 1'b1;
      doe_n_q <= 1'b1;
      be_n_q  <= 2'b11;
      addr_q  <= 23'd0;
      gp_q    <= 6'd0;
      dout_q  <= 16'd0;
      rdat_q  <= 16'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      abort_q <= abort_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      r_w_n_q <= r_w_n_d;
      doe_n_q <= doe_n_d;
      be_n_q  <= be_n_d;
      addr_q  <= addr_d;
      gp_q    <= gp_d;
      dout_q  <= dout_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
    end
  end

`ifdef EPB_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_q    <= 16'd0;
      err_st_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      err_st_q <= err_st_d;
      err_q    <= err_d;
    end
  end
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

  assign wb_dat_o      = rdat_q;
  assign wb_ack_o      = ack_q;
  assign epb_cs_n      = cs_n_q;
  assign epb_oe_n      = oe_n_q;
  assign epb_r_w_n     = r_w_n_q;
  assign epb_be_n      = be_n_q;
  assign epb_addr      = addr_q;
  assign epb_addr_gp   = gp_q;
  assign epb_data_o    = dout_q;
  assign epb_data_oe_n = doe_n_q;

endmodule
